// File: rtl/lfsr_gen.sv
// -----------------------------------------------------------------------------
// lfsr_gen
//
// Parametrised pseudo-random sequence generator (LFSR) used for BIST pattern
// generation and scrambler seeding. Supports Galois (right-shift) and
// Fibonacci forms, several shifts per enabled cycle, seed loading, recovery
// from the all-zero lock-up state, and measurement of the sequence period.
//
// Parameters
//   WIDTH        state width in bits (3..32)
//   TAPS         feedback mask, Galois right-shift form (WIDTH bits)
//   MODE         0 = Galois, 1 = Fibonacci
//   STEPS        single shifts applied per enabled cycle (1..WIDTH)
//   DEFAULT_SEED reset / recovery state, must be non-zero
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   enable    in   advance the state by STEPS shifts this cycle
//   load      in   load seed this cycle (wins over enable)
//   seed      in   value captured on load
//   lfsr_out  out  current LFSR state (registered)
//   lockup    out  one-cycle pulse: zero state / zero seed replaced by default
//   wrap      out  one-cycle pulse: sequence returned to the reference value
//   step_cnt  out  single shifts since the last load or wrap (registered)
//   period    out  step count captured at the last wrap; 0 until first wrap
// -----------------------------------------------------------------------------
module lfsr_gen #(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
   parameter int               MODE         = 0,
   parameter int               STEPS        = 1,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] lfsr_out,
   output logic             lockup,
   output logic             wrap,
   output logic [WIDTH-1:0] step_cnt,
   output logic [WIDTH-1:0] period
);

   // Elaboration-time parameter sanity checks.
   generate
      if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
         $error("lfsr_gen: WIDTH must be in 3..32");
      end
      if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
         $error("lfsr_gen: STEPS must be in 1..WIDTH");
      end
      if (MODE != 0 && MODE != 1) begin : g_bad_mode
         $error("lfsr_gen: MODE must be 0 or 1");
      end
      if (DEFAULT_SEED == '0) begin : g_bad_seed
         $error("lfsr_gen: DEFAULT_SEED must be non-zero");
      end
   endgenerate

   // Mirror of a vector: bit i takes bit WIDTH-1-i.
   function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = v[WIDTH-1-i];
      end
      return r;
   endfunction

   // The Galois mask describes the polynomial from the shift-out end, so the
   // Fibonacci form taps the mirrored positions to realise the same polynomial.
   localparam logic [WIDTH-1:0] FIB_MASK = bit_reverse(TAPS);
   localparam logic [WIDTH-1:0] STEP_INC = WIDTH'(STEPS);

   // One single shift of the register in the selected form.
   function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
      logic [WIDTH-1:0] r;
      if (MODE == 0) begin
         r = (s >> 1) ^ (s[0] ? TAPS : '0);
      end else begin
         r = {^(s & FIB_MASK), s[WIDTH-1:1]};
      end
      return r;
   endfunction

   logic [WIDTH-1:0] lfsr_q,   lfsr_d;
   logic [WIDTH-1:0] ref_q,    ref_d;
   logic [WIDTH-1:0] cnt_q,    cnt_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             lockup_q, lockup_d;
   logic             wrap_q,   wrap_d;

   logic [WIDTH-1:0] adv_state;
   logic             hit;
   logic [WIDTH-1:0] hit_k;

   // Unrolled multi-step advance. Every intermediate value is compared with
   // the reference so a wrap landing mid-cycle is still detected, and the
   // first matching shift index is kept for the period calculation.
   always_comb begin
      logic [WIDTH-1:0] s;
      s     = lfsr_q;
      hit   = 1'b0;
      hit_k = '0;
      for (int k = 1; k <= STEPS; k++) begin
         s = shift_once(s);
         if (!hit && (s == ref_q)) begin
            hit   = 1'b1;
            hit_k = WIDTH'(k);
         end
      end
      adv_state = s;
   end

   // Next-state selection in priority order: load, zero-state recovery,
   // advance, hold. Pulses default low so they last exactly one cycle.
   always_comb begin
      lfsr_d   = lfsr_q;
      ref_d    = ref_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      lockup_d = 1'b0;
      wrap_d   = 1'b0;
      if (load) begin
         if (seed != '0) begin
            lfsr_d = seed;
            ref_d  = seed;
         end else begin
            lfsr_d   = DEFAULT_SEED;
            ref_d    = DEFAULT_SEED;
            lockup_d = 1'b1;
         end
         cnt_d = '0;
      end else if (enable) begin
         if (lfsr_q == '0) begin
            // All-zero state is a fixed point of the shift; restart cleanly.
            lfsr_d   = DEFAULT_SEED;
            ref_d    = DEFAULT_SEED;
            cnt_d    = '0;
            lockup_d = 1'b1;
         end else begin
            lfsr_d = adv_state;
            if (hit) begin
               wrap_d   = 1'b1;
               period_d = cnt_q + hit_k;
               cnt_d    = '0;
            end else begin
               // Free-running count wraps silently for non-primitive masks.
               cnt_d = cnt_q + STEP_INC;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lfsr_q   <= DEFAULT_SEED;
         ref_q    <= DEFAULT_SEED;
         cnt_q    <= '0;
         period_q <= '0;
         lockup_q <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         lfsr_q   <= lfsr_d;
         ref_q    <= ref_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         lockup_q <= lockup_d;
         wrap_q   <= wrap_d;
      end
   end

   assign lfsr_out = lfsr_q;
   assign step_cnt = cnt_q;
   assign period   = period_q;
   assign lockup   = lockup_q;
   assign wrap     = wrap_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_gen
//
// Directed bench for lfsr_gen. Five instances cover the 16-bit Galois and
// Fibonacci forms, a 4-bit maximal-length Galois register at one and four
// shifts per cycle, and a 4-bit non-primitive mask that can reach the
// all-zero state. Expected results are queued when a step is driven and
// popped and compared once the DUT has clocked.
// -----------------------------------------------------------------------------
module tb_lfsr_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        en [5];
   logic        ld [5];
   logic [31:0] sd [5];

   logic [15:0] out0, out1, cnt0, cnt1, per0, per1;
   logic [3:0]  out2, out3, out4, cnt2, cnt3, cnt4, per2, per3, per4;
   logic        lk [5];
   logic        wr [5];

   logic [31:0] o_out [5];
   logic [31:0] o_cnt [5];
   logic [31:0] o_per [5];

   assign o_out[0] = {16'h0, out0};
   assign o_out[1] = {16'h0, out1};
   assign o_out[2] = {28'h0, out2};
   assign o_out[3] = {28'h0, out3};
   assign o_out[4] = {28'h0, out4};
   assign o_cnt[0] = {16'h0, cnt0};
   assign o_cnt[1] = {16'h0, cnt1};
   assign o_cnt[2] = {28'h0, cnt2};
   assign o_cnt[3] = {28'h0, cnt3};
   assign o_cnt[4] = {28'h0, cnt4};
   assign o_per[0] = {16'h0, per0};
   assign o_per[1] = {16'h0, per1};
   assign o_per[2] = {28'h0, per2};
   assign o_per[3] = {28'h0, per3};
   assign o_per[4] = {28'h0, per4};

   // 16-bit Galois, defaults
   lfsr_gen #(.WIDTH(16), .TAPS(16'hB400), .MODE(0), .STEPS(1), .DEFAULT_SEED(16'hACE1)) u_gal16 (
      .clock(clk), .reset(rst), .enable(en[0]), .load(ld[0]), .seed(sd[0][15:0]),
      .lfsr_out(out0), .lockup(lk[0]), .wrap(wr[0]), .step_cnt(cnt0), .period(per0));

   // 16-bit Fibonacci
   lfsr_gen #(.WIDTH(16), .TAPS(16'hB400), .MODE(1), .STEPS(1), .DEFAULT_SEED(16'hACE1)) u_fib16 (
      .clock(clk), .reset(rst), .enable(en[1]), .load(ld[1]), .seed(sd[1][15:0]),
      .lfsr_out(out1), .lockup(lk[1]), .wrap(wr[1]), .step_cnt(cnt1), .period(per1));

   // 4-bit x^4+x^3+1, one shift per cycle
   lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .MODE(0), .STEPS(1), .DEFAULT_SEED(4'h1)) u_gal4 (
      .clock(clk), .reset(rst), .enable(en[2]), .load(ld[2]), .seed(sd[2][3:0]),
      .lfsr_out(out2), .lockup(lk[2]), .wrap(wr[2]), .step_cnt(cnt2), .period(per2));

   // 4-bit x^4+x^3+1, four shifts per cycle
   lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .MODE(0), .STEPS(4), .DEFAULT_SEED(4'h1)) u_gal4s4 (
      .clock(clk), .reset(rst), .enable(en[3]), .load(ld[3]), .seed(sd[3][3:0]),
      .lfsr_out(out3), .lockup(lk[3]), .wrap(wr[3]), .step_cnt(cnt3), .period(per3));

   // 4-bit non-primitive mask: state 4'h7 shifts into 4'h0
   lfsr_gen #(.WIDTH(4), .TAPS(4'h3), .MODE(0), .STEPS(1), .DEFAULT_SEED(4'h1)) u_zero4 (
      .clock(clk), .reset(rst), .enable(en[4]), .load(ld[4]), .seed(sd[4][3:0]),
      .lfsr_out(out4), .lockup(lk[4]), .wrap(wr[4]), .step_cnt(cnt4), .period(per4));

   typedef struct {
      string       tag;
      int          d;
      logic [31:0] out;
      logic [31:0] cnt;
      logic [31:0] per;
      logic        lock;
      logic        wrp;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [3:0] gal4(input logic [3:0] s, input logic [3:0] t);
      return (s >> 1) ^ (s[0] ? t : 4'h0);
   endfunction

   task automatic push(input string tag, input int d, input logic [31:0] xo,
                       input logic [31:0] xc, input logic [31:0] xp,
                       input logic xl, input logic xw);
      exp_t e;
      e.tag = tag; e.d = d; e.out = xo; e.cnt = xc; e.per = xp;
      e.lock = xl; e.wrp = xw;
      sb.push_back(e);
   endtask

   task automatic compare_head();
      exp_t e;
      e = sb.pop_front();
      checks++;
      assert (o_out[e.d] === e.out) else begin
         errors++;
         $error("FAIL %s lfsr_out observed %0h expected %0h", e.tag, o_out[e.d], e.out);
      end
      checks++;
      assert (o_cnt[e.d] === e.cnt) else begin
         errors++;
         $error("FAIL %s step_cnt observed %0d expected %0d", e.tag, o_cnt[e.d], e.cnt);
      end
      checks++;
      assert (o_per[e.d] === e.per) else begin
         errors++;
         $error("FAIL %s period observed %0d expected %0d", e.tag, o_per[e.d], e.per);
      end
      checks++;
      assert (lk[e.d] === e.lock) else begin
         errors++;
         $error("FAIL %s lockup observed %b expected %b", e.tag, lk[e.d], e.lock);
      end
      checks++;
      assert (wr[e.d] === e.wrp) else begin
         errors++;
         $error("FAIL %s wrap observed %b expected %b", e.tag, wr[e.d], e.wrp);
      end
   endtask

   // Check without a clock edge (reset behaviour).
   task automatic check_now(input string tag, input int d, input logic [31:0] xo,
                            input logic [31:0] xc, input logic [31:0] xp,
                            input logic xl, input logic xw);
      push(tag, d, xo, xc, xp, xl, xw);
      compare_head();
   endtask

   // Drive one instance for one clock, then compare after the edge.
   task automatic cycle(input string tag, input int d, input logic e_en,
                        input logic e_ld, input logic [31:0] s,
                        input logic [31:0] xo, input logic [31:0] xc,
                        input logic [31:0] xp, input logic xl, input logic xw);
      for (int i = 0; i < 5; i++) begin
         en[i] = 1'b0;
         ld[i] = 1'b0;
      end
      en[d] = e_en;
      ld[d] = e_ld;
      sd[d] = s;
      push(tag, d, xo, xc, xp, xl, xw);
      @(posedge clk);
      #1;
      compare_head();
      en[d] = 1'b0;
      ld[d] = 1'b0;
   endtask

   initial begin
      logic [3:0] m;
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         en[i] = 1'b0;
         ld[i] = 1'b0;
         sd[i] = '0;
      end
      #2;
      check_now("rst_gal16", 0, 32'hACE1, 0, 0, 1'b0, 1'b0);
      check_now("rst_fib16", 1, 32'hACE1, 0, 0, 1'b0, 1'b0);
      check_now("rst_gal4",  2, 32'h1,    0, 0, 1'b0, 1'b0);
      check_now("rst_gal4s4",3, 32'h1,    0, 0, 1'b0, 1'b0);
      check_now("rst_zero4", 4, 32'h1,    0, 0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Galois and Fibonacci single steps from 0xACE1
      cycle("gal16_step1", 0, 1'b1, 1'b0, 0, 32'hE270, 1, 0, 1'b0, 1'b0);
      cycle("fib16_step1", 1, 1'b1, 1'b0, 0, 32'h5670, 1, 0, 1'b0, 1'b0);
      cycle("fib16_step2", 1, 1'b1, 1'b0, 0, 32'hAB38, 2, 0, 1'b0, 1'b0);

      // Full 15-state period, one shift per cycle
      m = 4'h1;
      for (int k = 1; k <= 15; k++) begin
         m = gal4(m, 4'hC);
         cycle($sformatf("gal4_step%0d", k), 2, 1'b1, 1'b0, 0, {28'h0, m},
               (k == 15) ? 0 : k, (k == 15) ? 15 : 0, 1'b0, (k == 15));
      end
      cycle("gal4_hold", 2, 1'b0, 1'b0, 0, 32'h1, 0, 15, 1'b0, 1'b0);

      // Four shifts per cycle: wrap at shift 3 of the fourth cycle
      cycle("s4_load", 3, 1'b0, 1'b1, 32'h1, 32'h1, 0, 0, 1'b0, 1'b0);
      cycle("s4_c1",   3, 1'b1, 1'b0, 0, 32'hD, 4,  0,  1'b0, 1'b0);
      cycle("s4_c2",   3, 1'b1, 1'b0, 0, 32'h7, 8,  0,  1'b0, 1'b0);
      cycle("s4_c3",   3, 1'b1, 1'b0, 0, 32'h8, 12, 0,  1'b0, 1'b0);
      cycle("s4_c4",   3, 1'b1, 1'b0, 0, 32'hC, 0,  15, 1'b0, 1'b1);
      cycle("s4_hold", 3, 1'b0, 1'b0, 0, 32'hC, 0,  15, 1'b0, 1'b0);

      // Zero seed replaced by default, lockup for one cycle
      cycle("zseed_load", 2, 1'b0, 1'b1, 0, 32'h1, 0, 15, 1'b1, 1'b0);
      cycle("zseed_hold", 2, 1'b0, 1'b0, 0, 32'h1, 0, 15, 1'b0, 1'b0);

      // Corrupted all-zero state reached through a non-primitive mask
      cycle("z4_load7",   4, 1'b0, 1'b1, 32'h7, 32'h7, 0, 0, 1'b0, 1'b0);
      cycle("z4_to_zero", 4, 1'b1, 1'b0, 0, 32'h0, 1, 0, 1'b0, 1'b0);
      cycle("z4_idle0",   4, 1'b0, 1'b0, 0, 32'h0, 1, 0, 1'b0, 1'b0);
      cycle("z4_recover", 4, 1'b1, 1'b0, 0, 32'h1, 0, 0, 1'b1, 1'b0);
      cycle("z4_after",   4, 1'b0, 1'b0, 0, 32'h1, 0, 0, 1'b0, 1'b0);

      // Load has priority over enable
      cycle("ld_en_both", 0, 1'b1, 1'b1, 32'h1234, 32'h1234, 0, 0, 1'b0, 1'b0);
      cycle("gal16_adv",  0, 1'b1, 1'b0, 0, 32'h091A, 1, 0, 1'b0, 1'b0);

      // Pending lockup pulse, then reset asserted between clock edges
      cycle("z4_pend", 4, 1'b0, 1'b1, 0, 32'h1, 0, 0, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_now("mid_rst_gal16", 0, 32'hACE1, 0, 0, 1'b0, 1'b0);
      check_now("mid_rst_fib16", 1, 32'hACE1, 0, 0, 1'b0, 1'b0);
      check_now("mid_rst_gal4",  2, 32'h1,    0, 0, 1'b0, 1'b0);
      check_now("mid_rst_zero4", 4, 32'h1,    0, 0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
